// File: rtl/dmi_pkg.sv
// Shared DMI definitions: word field positions, request/response op encodings,
// responder FSM states and a response-word packing helper.
package dmi_pkg;

  localparam int unsigned DMI_ADDR_W   = 7;
  localparam int unsigned DMI_DATA_W   = 32;
  localparam int unsigned DMI_WORD_W   = 41;

  localparam int unsigned DMI_OP_LSB   = 0;
  localparam int unsigned DMI_OP_MSB   = 1;
  localparam int unsigned DMI_DATA_LSB = 2;
  localparam int unsigned DMI_DATA_MSB = 33;
  localparam int unsigned DMI_ADDR_LSB = 34;
  localparam int unsigned DMI_ADDR_MSB = 40;

  typedef enum logic [1:0] {
    DMI_OP_NOP   = 2'd0,
    DMI_OP_READ  = 2'd1,
    DMI_OP_WRITE = 2'd2,
    DMI_OP_RSVD  = 2'd3
  } dmi_req_op_e;

  typedef enum logic [1:0] {
    DMI_RESP_SUCCESS = 2'd0,
    DMI_RESP_FAILED  = 2'd2,
    DMI_RESP_BUSY    = 2'd3
  } dmi_resp_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_WAIT,
    ST_RESP
  } dmi_state_e;

  function automatic logic [DMI_WORD_W-1:0] dmi_pack_resp(
    input logic [DMI_ADDR_W-1:0] addr,
    input logic [DMI_DATA_W-1:0] data,
    input dmi_resp_op_e          op
  );
    return {addr, data, op};
  endfunction

endpackage

// File: rtl/dmi_responder.sv
// Core-side DMI terminating endpoint. Accepts one request at a time, forwards
// READ/WRITE to the debug-module register port and returns a status response.
// A stalled access is converted into a BUSY response after TIMEOUT_CYCLES.
// Optional: define DMI_ADDR_CHECK_EN to reject READ/WRITE outside
// [DM_ADDR_MIN, DM_ADDR_MAX] without touching the register port.
module dmi_responder
  import dmi_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 41,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [6:0]  DM_ADDR_MIN    = 7'h04,
  parameter logic [6:0]  DM_ADDR_MAX    = 7'h40
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [DATA_WIDTH-1:0] req_data_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  output logic [DATA_WIDTH-1:0] resp_data_o,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic                  dm_req_valid_o,
  input  logic                  dm_req_ready_i,
  output logic                  dm_we_o,
  output logic [6:0]            dm_addr_o,
  output logic [31:0]           dm_wdata_o,
  input  logic                  dm_rvalid_i,
  input  logic [31:0]           dm_rdata_i,
  input  logic                  dm_err_i
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

`ifdef DMI_ADDR_CHECK_EN
  localparam bit ADDR_CHECK = 1'b1;
`else
  localparam bit ADDR_CHECK = 1'b0;
`endif

  dmi_state_e                state;
  logic [CNT_W-1:0]          cnt;
  logic [CNT_W-1:0]          cnt_inc;
  logic                      timeout_hit;
  logic [DMI_ADDR_W-1:0]     in_addr;
  logic [DMI_DATA_W-1:0]     in_data;
  dmi_req_op_e               in_op;
  logic                      addr_reject;

  assign in_addr = req_data_i[DMI_ADDR_MSB:DMI_ADDR_LSB];
  assign in_data = req_data_i[DMI_DATA_MSB:DMI_DATA_LSB];
  assign in_op   = dmi_req_op_e'(req_data_i[DMI_OP_MSB:DMI_OP_LSB]);

  assign addr_reject = ADDR_CHECK && ((in_addr < DM_ADDR_MIN) || (in_addr > DM_ADDR_MAX));

  // The timeout fires on the cycle whose increment would reach TIMEOUT_CYCLES,
  // so exactly TIMEOUT_CYCLES cycles are spent in ACCESS+WAIT.
  assign cnt_inc     = cnt + 1'b1;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_inc == CNT_W'(TIMEOUT_CYCLES));

  assign req_ready_o = (state == ST_IDLE);

  // Request/response FSM with registered register-port and response outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state          <= ST_IDLE;
      cnt            <= '0;
      resp_valid_o   <= 1'b0;
      resp_data_o    <= '0;
      dm_req_valid_o <= 1'b0;
      dm_we_o        <= 1'b0;
      dm_addr_o      <= '0;
      dm_wdata_o     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid_i) begin
            cnt <= '0;
            case (in_op)
              DMI_OP_NOP: begin
                state        <= ST_RESP;
                resp_valid_o <= 1'b1;
                resp_data_o  <= dmi_pack_resp(in_addr, '0, DMI_RESP_SUCCESS);
              end
              DMI_OP_READ, DMI_OP_WRITE: begin
                if (addr_reject) begin
                  state        <= ST_RESP;
                  resp_valid_o <= 1'b1;
                  resp_data_o  <= dmi_pack_resp(in_addr, '0, DMI_RESP_FAILED);
                end else begin
                  state          <= ST_ACCESS;
                  dm_req_valid_o <= 1'b1;
                  dm_we_o        <= (in_op == DMI_OP_WRITE);
                  dm_addr_o      <= in_addr;
                  dm_wdata_o     <= in_data;
                end
              end
              default: begin
                state        <= ST_RESP;
                resp_valid_o <= 1'b1;
                resp_data_o  <= dmi_pack_resp(in_addr, '0, DMI_RESP_FAILED);
              end
            endcase
          end
        end
        ST_ACCESS: begin
          cnt <= cnt_inc;
          if (timeout_hit) begin
            state          <= ST_RESP;
            dm_req_valid_o <= 1'b0;
            resp_valid_o   <= 1'b1;
            resp_data_o    <= dmi_pack_resp(dm_addr_o, '0, DMI_RESP_BUSY);
          end else if (dm_req_ready_i) begin
            state          <= ST_WAIT;
            dm_req_valid_o <= 1'b0;
          end
        end
        ST_WAIT: begin
          cnt <= cnt_inc;
          if (dm_rvalid_i) begin
            state        <= ST_RESP;
            resp_valid_o <= 1'b1;
            resp_data_o  <= dmi_pack_resp(dm_addr_o,
                                          (!dm_we_o && !dm_err_i) ? dm_rdata_i : '0,
                                          dm_err_i ? DMI_RESP_FAILED : DMI_RESP_SUCCESS);
          end else if (timeout_hit) begin
            state        <= ST_RESP;
            resp_valid_o <= 1'b1;
            resp_data_o  <= dmi_pack_resp(dm_addr_o, '0, DMI_RESP_BUSY);
          end
        end
        ST_RESP: begin
          if (resp_ready_i) begin
            state        <= ST_IDLE;
            resp_valid_o <= 1'b0;
            resp_data_o  <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
